subpel_downconv1x1: RTL

- Inverse-direction companion to the sub-pixel upsampler: performs pixel unshuffle (space-to-depth, factor R), then a 1x1 convolution to OUT_CHANNELS.
- Used on the analysis/encoder path to downsample feature maps by R.
- One shared signed MAC is time-multiplexed, one MAC per clock.
- Uses a start/busy/done handshake. The result is presented on a flat output register.

---
 rtl/subpel_pkg.sv | 33 +++
 rtl/subpel_downconv1x1_mac.sv | 37 +++
 rtl/subpel_downconv1x1.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/subpel_pkg.sv
// Shared types and index helpers for the pixel-unshuffle + 1x1 conv block.
package subpel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k) + 1;
  endfunction

  // Unshuffled channel k = c*R*R + r1*R + r2 reads input[c][h*R+r1][w*R+r2]
  function automatic int unsh_src_idx(input int k, input int h, input int w,
                                      input int r, input int in_h, input int in_w);
    int c, r1, r2;
    c  = k / (r * r);
    r1 = (k / r) % r;
    r2 = k % r;
    return (c * in_h + h * r + r1) * in_w + w * r + r2;
  endfunction

  function automatic int out_idx(input int o, input int h, input int w,
                                 input int oh, input int ow);
    return (o * oh + h) * ow + w;
  endfunction

endpackage

// File: rtl/subpel_downconv1x1_mac.sv
// Signed multiply-accumulate; clear-load seeds the sum with a bias term.
module mac_unit #(
  parameter int DW = 16,
  parameter int AW = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_load,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_bias,
  output logic [DW-1:0] o_sum
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_prod_ext;
  logic signed [AW-1:0]   w_bias_ext;
  logic signed [AW-1:0]   w_next;
  logic signed [AW-1:0]   r_acc;

  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_bias_ext = {{(AW-DW){i_bias[DW-1]}}, i_bias};
  assign w_next     = i_load ? (w_bias_ext + w_prod_ext) : (r_acc + w_prod_ext);
  // The sum including this cycle's product, so the last term is visible at once
  assign o_sum      = w_next[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

endmodule

// File: rtl/subpel_downconv1x1.sv
// Pixel unshuffle by R followed by a 1x1 conv, one shared MAC per clock.
module subpel_downconv1x1
  import subpel_pkg::*;
#(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int R            = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] input_tensor_flat,
  input  logic [OUT_CHANNELS*IN_CHANNELS*R*R*DATA_WIDTH-1:0]   weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                    bias_flat,
  output logic busy,
  output logic done,
  output logic [OUT_CHANNELS*(IN_HEIGHT/R)*(IN_WIDTH/R)*DATA_WIDTH-1:0] output_tensor_flat
);

  localparam int K  = IN_CHANNELS * R * R;
  localparam int OH = IN_HEIGHT / R;
  localparam int OW = IN_WIDTH / R;
  localparam int AW = acc_width(DATA_WIDTH, K);
  localparam int KW = cnt_w(K);
  localparam int WW = cnt_w(OW);
  localparam int HW = cnt_w(OH);
  localparam int OC = cnt_w(OUT_CHANNELS);
  localparam int IN_BITS  = IN_CHANNELS * IN_HEIGHT * IN_WIDTH * DATA_WIDTH;
  localparam int WT_BITS  = OUT_CHANNELS * K * DATA_WIDTH;
  localparam int B_BITS   = OUT_CHANNELS * DATA_WIDTH;
  localparam int OUT_BITS = OUT_CHANNELS * OH * OW * DATA_WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [WW-1:0] W_LAST = WW'(OW - 1);
  localparam logic [HW-1:0] H_LAST = HW'(OH - 1);
  localparam logic [OC-1:0] O_LAST = OC'(OUT_CHANNELS - 1);

  state_t r_state, w_state_next;

  logic [IN_BITS-1:0]  r_in;
  logic [WT_BITS-1:0]  r_wt;
  logic [B_BITS-1:0]   r_bias;
  logic [OUT_BITS-1:0] r_res;
  logic [KW-1:0] r_k;
  logic [WW-1:0] r_w;
  logic [HW-1:0] r_h;
  logic [OC-1:0] r_o;
  logic r_busy, r_done;

  logic w_mac_en, w_load;
  logic w_last_k, w_last_w, w_last_h, w_last_o, w_last_mac;
  logic [DATA_WIDTH-1:0] w_a, w_b, w_bias, w_sum;
  int w_src, w_wi, w_oi;

  assign w_last_k   = (r_k == K_LAST);
  assign w_last_w   = (r_w == W_LAST);
  assign w_last_h   = (r_h == H_LAST);
  assign w_last_o   = (r_o == O_LAST);
  assign w_last_mac = w_last_k && w_last_w && w_last_h && w_last_o;
  assign w_load     = (r_k == '0);

  always_comb begin
    w_state_next = r_state;
    w_mac_en     = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN: begin
        w_mac_en = 1'b1;
        if (w_last_mac) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_src  = unsh_src_idx(int'(r_k), int'(r_h), int'(r_w), R, IN_HEIGHT, IN_WIDTH);
    w_wi   = int'(r_o) * K + int'(r_k);
    w_oi   = out_idx(int'(r_o), int'(r_h), int'(r_w), OH, OW);
    w_a    = r_in[w_src*DATA_WIDTH +: DATA_WIDTH];
    w_b    = r_wt[w_wi*DATA_WIDTH +: DATA_WIDTH];
    w_bias = r_bias[int'(r_o)*DATA_WIDTH +: DATA_WIDTH];
  end

  mac_unit #(
    .DW (DATA_WIDTH),
    .AW (AW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_mac_en),
    .i_load (w_load),
    .i_a    (w_a),
    .i_b    (w_b),
    .i_bias (w_bias),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_in               <= '0;
      r_wt               <= '0;
      r_bias             <= '0;
      r_res              <= '0;
      r_k                <= '0;
      r_w                <= '0;
      r_h                <= '0;
      r_o                <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      output_tensor_flat <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_in   <= input_tensor_flat;
            r_wt   <= weights_flat;
            r_bias <= bias_flat;
            r_k    <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_o    <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_last_k) begin
            r_res[w_oi*DATA_WIDTH +: DATA_WIDTH] <= w_sum;
            r_k <= '0;
            if (w_last_w) begin
              r_w <= '0;
              if (w_last_h) begin
                r_h <= '0;
                r_o <= w_last_o ? '0 : r_o + 1'b1;
              end else begin
                r_h <= r_h + 1'b1;
              end
            end else begin
              r_w <= r_w + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_DONE: begin
          output_tensor_flat <= r_res;
          r_done             <= 1'b1;
          r_busy             <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
